// File: rtl/cdb_data_controller_pkg.sv
// Shared CPU parameters for the CDB data controller: bus widths, FU class ranges, NULL RB index.
// The CDB_COLLISION_EN macro is consumed by the files that import this package.
package cdb_data_controller_pkg;

   localparam int WORD_SIZE   = 32;
   localparam int RB_SIZE     = 16;
   localparam int RB_INDEX    = 4;
   localparam int FU_INDEX    = 4;
   localparam int ADDER_NUM   = 3;
   localparam int MULTER_NUM  = 2;
   localparam int LOAD_NUM    = 3;
   localparam int BRANCH_NUM  = 1;
   localparam int STORER_NUM  = 2;
   localparam int FU_NUM      = ADDER_NUM + MULTER_NUM + LOAD_NUM + BRANCH_NUM + STORER_NUM;

   localparam int ADDER_BASE  = 0;
   localparam int MULTER_BASE = ADDER_BASE + ADDER_NUM;
   localparam int LOAD_BASE   = MULTER_BASE + MULTER_NUM;
   localparam int BRANCH_BASE = LOAD_BASE + LOAD_NUM;
   localparam int STORER_BASE = BRANCH_BASE + BRANCH_NUM;

   localparam logic [RB_INDEX-1:0] RB_NULL = 4'd0;

   // Store FUs occupy the top STORER_NUM FU indices.
   function automatic logic is_store_fu(input int f);
      if (f >= STORER_BASE) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/cdb_data_controller_lane_mux.sv
// Per-lane priority select: picks the lowest-index valid FU targeting this RB lane.
// With CDB_COLLISION_EN, also flags two or more FUs targeting the lane in one cycle.
module cdb_lane_mux
   import cdb_data_controller_pkg::*;
#(
   parameter int LANE = 0
) (
   input  logic [FU_NUM*WORD_SIZE-1:0]     data_bus,
   input  logic [FU_NUM-1:0]               valid_bus,
   input  logic [STORER_NUM*WORD_SIZE-1:0] addr_bus,
   input  logic [FU_NUM*RB_INDEX-1:0]      RB_index_bus,
   output logic                            hit_o,
   output logic [WORD_SIZE-1:0]            data_o,
   output logic [WORD_SIZE-1:0]            addr_o
`ifdef CDB_COLLISION_EN
   ,
   output logic                            conflict_o
`endif
);

   localparam logic [RB_INDEX-1:0] LANE_IDX = RB_INDEX'(LANE);

   logic [FU_NUM-1:0]    match_s;
   logic [WORD_SIZE-1:0] fu_data_s [FU_NUM];
   logic [WORD_SIZE-1:0] fu_addr_s [FU_NUM];
   logic                 conflict_s;

   for (genvar f = 0; f < FU_NUM; f++) begin : g_fu
      assign match_s[f]   = valid_bus[f] && (RB_index_bus[f*RB_INDEX +: RB_INDEX] == LANE_IDX)
                            && (LANE_IDX != RB_NULL);
      assign fu_data_s[f] = data_bus[f*WORD_SIZE +: WORD_SIZE];
      if (is_store_fu(f)) begin : g_store
         assign fu_addr_s[f] = addr_bus[(f-STORER_BASE)*WORD_SIZE +: WORD_SIZE];
      end else begin : g_nostore
         assign fu_addr_s[f] = 32'd0;
      end
   end

   // Ascending scan so the first match (lowest FU index) wins; later matches only flag a conflict.
   always_comb begin
      hit_o      = 1'b0;
      data_o     = 32'd0;
      addr_o     = 32'd0;
      conflict_s = 1'b0;
      for (int f = 0; f < FU_NUM; f++) begin
         if (match_s[f] && hit_o) begin
            conflict_s = 1'b1;
         end else if (match_s[f]) begin
            hit_o  = 1'b1;
            data_o = fu_data_s[f];
            addr_o = fu_addr_s[f];
         end else begin
            conflict_s = conflict_s;
         end
      end
   end

`ifdef CDB_COLLISION_EN
   assign conflict_o = conflict_s;
`endif

endmodule

// File: rtl/cdb_data_controller.sv
// Routes FU results onto the per-RB-entry CDB lanes with one cycle of latency.
// Optional CDB_COLLISION_EN adds a registered same-lane collision flag.
module cdb_data_controller
   import cdb_data_controller_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic [FU_NUM*WORD_SIZE-1:0]     data_bus,
   input  logic [FU_NUM-1:0]               valid_bus,
   input  logic [STORER_NUM*WORD_SIZE-1:0] addr_bus,
   input  logic [FU_NUM*RB_INDEX-1:0]      RB_index_bus,
   output logic [RB_SIZE*WORD_SIZE-1:0]    CDB_data_data,
   output logic [RB_SIZE-1:0]              CDB_data_valid,
   output logic [RB_SIZE*WORD_SIZE-1:0]    CDB_data_addr
`ifdef CDB_COLLISION_EN
   ,
   output logic                            collision
`endif
);

   logic [RB_SIZE-1:0]                hit_s;
   logic [WORD_SIZE-1:0]              mux_data_s [RB_SIZE];
   logic [WORD_SIZE-1:0]              mux_addr_s [RB_SIZE];

   logic [RB_SIZE-1:0]                valid_d, valid_q;
   logic [RB_SIZE-1:0][WORD_SIZE-1:0] data_d,  data_q;
   logic [RB_SIZE-1:0][WORD_SIZE-1:0] addr_d,  addr_q;

`ifdef CDB_COLLISION_EN
   logic [RB_SIZE-1:0]                conflict_s;
   logic                              collision_d, collision_q;
`endif

   for (genvar r = 0; r < RB_SIZE; r++) begin : g_lane
      cdb_lane_mux #(.LANE(r)) u_mux (
         .data_bus     (data_bus),
         .valid_bus    (valid_bus),
         .addr_bus     (addr_bus),
         .RB_index_bus (RB_index_bus),
         .hit_o        (hit_s[r]),
         .data_o       (mux_data_s[r]),
         .addr_o       (mux_addr_s[r])
`ifdef CDB_COLLISION_EN
         ,
         .conflict_o   (conflict_s[r])
`endif
      );
   end

   // Next-state: a hit loads the lane; otherwise data/addr hold and valid drops.
   always_comb begin
      valid_d = hit_s;
      data_d  = data_q;
      addr_d  = addr_q;
      for (int r = 0; r < RB_SIZE; r++) begin
         if (hit_s[r]) begin
            data_d[r] = mux_data_s[r];
            addr_d[r] = mux_addr_s[r];
         end else begin
            data_d[r] = data_q[r];
            addr_d[r] = addr_q[r];
         end
      end
   end

   // Lane registers; reset has priority over any simultaneous FU result.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         data_q  <= '0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
      end
   end

`ifdef CDB_COLLISION_EN
   assign collision_d = |conflict_s;

   // Registered collision flag, one cycle after the conflicting presentation.
   always_ff @(posedge clk) begin
      if (reset) begin
         collision_q <= 1'b0;
      end else begin
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;
`endif

   assign CDB_data_valid = valid_q;
   assign CDB_data_data  = data_q;
   assign CDB_data_addr  = addr_q;

endmodule

// File: tb/tb_cdb_data_controller.sv
// Directed self-checking bench for cdb_data_controller; covers CDB_COLLISION_EN when defined.
module tb_cdb_data_controller;

   localparam int W   = 32;
   localparam int RBS = 16;
   localparam int RBI = 4;
   localparam int FUN = 11;
   localparam int STN = 2;

   logic               clk;
   logic               reset;
   logic [FUN*W-1:0]   data_bus;
   logic [FUN-1:0]     valid_bus;
   logic [STN*W-1:0]   addr_bus;
   logic [FUN*RBI-1:0] RB_index_bus;
   logic [RBS*W-1:0]   CDB_data_data;
   logic [RBS-1:0]     CDB_data_valid;
   logic [RBS*W-1:0]   CDB_data_addr;
`ifdef CDB_COLLISION_EN
   logic               collision;
`endif

   int checks = 0;
   int errors = 0;

   cdb_data_controller dut (
      .clk            (clk),
      .reset          (reset),
      .data_bus       (data_bus),
      .valid_bus      (valid_bus),
      .addr_bus       (addr_bus),
      .RB_index_bus   (RB_index_bus),
      .CDB_data_data  (CDB_data_data),
      .CDB_data_valid (CDB_data_valid),
      .CDB_data_addr  (CDB_data_addr)
`ifdef CDB_COLLISION_EN
      ,
      .collision      (collision)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_fu();
      data_bus     = '0;
      valid_bus    = '0;
      addr_bus     = '0;
      RB_index_bus = '0;
   endtask

   task automatic set_fu(input int f, input logic [W-1:0] d, input logic [RBI-1:0] r);
      data_bus[f*W +: W]         = d;
      valid_bus[f]               = 1'b1;
      RB_index_bus[f*RBI +: RBI] = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] lane_data(input int r);
      return CDB_data_data[r*W +: W];
   endfunction

   function automatic logic [W-1:0] lane_addr(input int r);
      return CDB_data_addr[r*W +: W];
   endfunction

   initial begin
      // 1: reset discards a simultaneous FU result
      reset = 1'b1;
      clear_fu();
      set_fu(0, 32'h0000_0055, 4'd3);
      tick();
      chk("rst_valid", {16'd0, CDB_data_valid}, 32'd0);
      chk("rst_data_or", {31'd0, |CDB_data_data}, 32'd0);
      chk("rst_addr_or", {31'd0, |CDB_data_addr}, 32'd0);
`ifdef CDB_COLLISION_EN
      chk("rst_collision", {31'd0, collision}, 32'd0);
`endif

      // 2: ALU result on lane 2, valid for one cycle, data holds
      reset = 1'b0;
      clear_fu();
      set_fu(1, 32'h0000_1234, 4'd2);
      tick();
      chk("l2_valid", {16'd0, CDB_data_valid}, 32'h0000_0004);
      chk("l2_data", lane_data(2), 32'h0000_1234);
      chk("l2_addr", lane_addr(2), 32'd0);
      clear_fu();
      tick();
      chk("l2_valid_drop", {16'd0, CDB_data_valid}, 32'd0);
      chk("l2_data_hold", lane_data(2), 32'h0000_1234);

      // 3: store FU 9 forwards addr_bus lane 0
      set_fu(9, 32'h0000_0007, 4'd5);
      addr_bus[0 +: W] = 32'h0000_0040;
      tick();
      chk("st_valid", {16'd0, CDB_data_valid}, 32'h0000_0020);
      chk("st_data", lane_data(5), 32'h0000_0007);
      chk("st_addr", lane_addr(5), 32'h0000_0040);
      clear_fu();
      tick();
      chk("st_valid_drop", {16'd0, CDB_data_valid}, 32'd0);
      chk("st_addr_hold", lane_addr(5), 32'h0000_0040);

      // 4: three FUs to three distinct lanes in one cycle
      set_fu(0, 32'h0000_0011, 4'd1);
      set_fu(5, 32'h0000_0044, 4'd4);
      set_fu(10, 32'h0000_0066, 4'd6);
      addr_bus[W +: W] = 32'h0000_0080;
      tick();
      chk("multi_valid", {16'd0, CDB_data_valid}, 32'h0000_0052);
      chk("multi_d1", lane_data(1), 32'h0000_0011);
      chk("multi_d4", lane_data(4), 32'h0000_0044);
      chk("multi_d6", lane_data(6), 32'h0000_0066);
      chk("multi_a1", lane_addr(1), 32'd0);
      chk("multi_a6", lane_addr(6), 32'h0000_0080);
`ifdef CDB_COLLISION_EN
      chk("multi_collision", {31'd0, collision}, 32'd0);
`endif

      // 5: same-lane conflict, lowest FU index wins
      clear_fu();
      set_fu(2, 32'h0000_000A, 4'd3);
      set_fu(7, 32'h0000_000B, 4'd3);
      tick();
      chk("conf_valid", {16'd0, CDB_data_valid}, 32'h0000_0008);
      chk("conf_data", lane_data(3), 32'h0000_000A);
`ifdef CDB_COLLISION_EN
      chk("conf_collision", {31'd0, collision}, 32'd1);
`endif
      clear_fu();
      tick();
      chk("conf_valid_drop", {16'd0, CDB_data_valid}, 32'd0);
`ifdef CDB_COLLISION_EN
      chk("conf_collision_drop", {31'd0, collision}, 32'd0);
`endif

      // 6: NULL index is ignored
      set_fu(3, 32'h0000_0099, 4'd0);
      tick();
      chk("null_valid", {16'd0, CDB_data_valid}, 32'd0);
      chk("null_d0", lane_data(0), 32'd0);

      // 7: reset mid-flow wins over a valid FU
      clear_fu();
      set_fu(1, 32'h0000_0077, 4'd2);
      reset = 1'b1;
      tick();
      chk("midrst_valid", {16'd0, CDB_data_valid}, 32'd0);
      chk("midrst_d2", lane_data(2), 32'd0);
      chk("midrst_a5", lane_addr(5), 32'd0);
      reset = 1'b0;
      clear_fu();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
